// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit
// Purpose  : Front-end fetch stage. Owns the program counter, issues word
//            fetches to a 1-cycle-latency synchronous instruction memory,
//            buffers returned words in a small FIFO and hands them to decode
//            over a valid/ready handshake. A redirect flushes the buffer and
//            any in-flight response and restarts fetch at the new target.
// Ports    :
//   CLK_pi          in   1   clock, rising edge
//   CPU_RESET_pi    in   1   asynchronous active-high reset
//   imem_req_po     out  1   fetch request this cycle
//   imem_addr_po    out  32  word-aligned fetch address
//   imem_rdata_pi   in   32  instruction data, valid 1 cycle after request
//   if_valid_po     out  1   buffer head holds a valid instruction
//   if_instr_po     out  32  instruction at buffer head
//   if_pc_po        out  32  PC of the head instruction
//   id_ready_pi     in   1   decode accepts the head this cycle
//   redirect_pi     in   1   flush and restart fetch
//   redirect_pc_pi  in   32  restart target (bits [1:0] ignored)
//   fetch_count_po  out  32  instructions delivered to decode
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          FB_DEPTH = 2
) (
    input  logic        CLK_pi,
    input  logic        CPU_RESET_pi,
    output logic        imem_req_po,
    output logic [31:0] imem_addr_po,
    input  logic [31:0] imem_rdata_pi,
    output logic        if_valid_po,
    output logic [31:0] if_instr_po,
    output logic [31:0] if_pc_po,
    input  logic        id_ready_pi,
    input  logic        redirect_pi,
    input  logic [31:0] redirect_pc_pi,
    output logic [31:0] fetch_count_po
);

    localparam int c_PTR_W = (FB_DEPTH > 1) ? $clog2(FB_DEPTH) : 1;
    localparam int c_CNT_W = $clog2(FB_DEPTH + 1);
    localparam int c_OCC_W = c_CNT_W + 1;
    localparam logic [c_OCC_W-1:0] c_DEPTH = c_OCC_W'(FB_DEPTH);
    localparam logic [c_PTR_W-1:0] c_LAST  = c_PTR_W'(FB_DEPTH - 1);

    logic [31:0]        r_pc;
    logic               r_inflight;
    logic [31:0]        r_inflight_pc;
    logic [31:0]        r_fetch_count;
    logic [31:0]        r_hold_instr;
    logic [31:0]        r_hold_pc;
    logic [31:0]        r_fb_instr [FB_DEPTH];
    logic [31:0]        r_fb_pc    [FB_DEPTH];
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_CNT_W-1:0] r_count;

    logic               w_valid;
    logic               w_pop;
    logic               w_push;
    logic               w_issue;
    logic [c_OCC_W-1:0] w_occ;
    logic               w_unused_bits;

    function automatic logic [c_PTR_W-1:0] f_next_ptr(input logic [c_PTR_W-1:0] p);
        return (p == c_LAST) ? '0 : p + c_PTR_W'(1);
    endfunction

    assign w_valid = (r_count != '0);
    assign w_pop   = w_valid & id_ready_pi;
    // The response of the request issued last cycle lands now; a redirect
    // this cycle kills it together with the buffered entries.
    assign w_push  = r_inflight & ~redirect_pi;
    assign w_occ   = {1'b0, r_count} + c_OCC_W'(r_inflight);

    // Issue only when the returning word is guaranteed a buffer slot; a pop
    // this cycle frees exactly one slot, which keeps full-rate streaming.
    // Reset gating keeps the request low while reset is asserted.
    assign w_issue = ~CPU_RESET_pi & ~redirect_pi &
                     ((w_occ < c_DEPTH) | ((w_occ == c_DEPTH) & w_pop));

    assign w_unused_bits = &{1'b0, redirect_pc_pi[1:0]};

    always_ff @(posedge CLK_pi or posedge CPU_RESET_pi) begin
        if (CPU_RESET_pi) begin
            r_pc          <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= 32'h0;
            r_fetch_count <= 32'h0;
            r_hold_instr  <= 32'h0;
            r_hold_pc     <= 32'h0;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_count       <= '0;
            for (int i = 0; i < FB_DEPTH; i++) begin
                r_fb_instr[i] <= 32'h0;
                r_fb_pc[i]    <= 32'h0;
            end
        end else begin
            // Decode consumed the head even if a redirect coincides.
            if (w_pop) begin
                r_fetch_count <= r_fetch_count + 32'd1;
            end

            // Remember the head so the outputs hold their last value once
            // the buffer drains.
            if (w_valid) begin
                r_hold_instr <= r_fb_instr[r_rd_ptr];
                r_hold_pc    <= r_fb_pc[r_rd_ptr];
            end

            if (redirect_pi) begin
                r_pc       <= {redirect_pc_pi[31:2], 2'b00};
                r_inflight <= 1'b0;
                r_rd_ptr   <= '0;
                r_wr_ptr   <= '0;
                r_count    <= '0;
            end else begin
                r_inflight <= w_issue;
                if (w_issue) begin
                    r_pc          <= r_pc + 32'd4;
                    r_inflight_pc <= r_pc;
                end

                if (w_push) begin
                    r_fb_instr[r_wr_ptr] <= imem_rdata_pi;
                    r_fb_pc[r_wr_ptr]    <= r_inflight_pc;
                    r_wr_ptr             <= f_next_ptr(r_wr_ptr);
                end
                if (w_pop) begin
                    r_rd_ptr <= f_next_ptr(r_rd_ptr);
                end

                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + c_CNT_W'(1);
                    2'b01:   r_count <= r_count - c_CNT_W'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    assign imem_req_po    = w_issue;
    assign imem_addr_po   = r_pc;
    assign if_valid_po    = w_valid;
    assign if_instr_po    = w_valid ? r_fb_instr[r_rd_ptr] : r_hold_instr;
    assign if_pc_po       = w_valid ? r_fb_pc[r_rd_ptr]    : r_hold_pc;
    assign fetch_count_po = r_fetch_count;

endmodule
`default_nettype wire
